// File: rtl/program_loader_ctrl_if.sv
// Byte-stream input and program-memory/core-control outputs of the boot loader.
// master: the loader itself; slave: the surrounding UART/memory/core environment.
interface program_loader_ctrl_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        mem_sel;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        cpu_reset_n;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_loaded;

  modport master (
    input  rx_valid, rx_data,
    output mem_sel, mem_addr, mem_we, mem_wdata,
    output cpu_reset_n, load_done, load_error, words_loaded
  );

  modport slave (
    output rx_valid, rx_data,
    input  mem_sel, mem_addr, mem_we, mem_wdata,
    input  cpu_reset_n, load_done, load_error, words_loaded
  );
endinterface

// File: rtl/program_loader_ctrl.sv
// Boot loader: parses SYNC/LEN/data frames from a UART byte stream, writes words to program
// memory from address 0, then releases the core. LOADER_CHECKSUM_EN adds a trailing XOR check.
module program_loader_ctrl #(
  parameter int         MEM_WORDS = 1024,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic                   clk,
  input logic                   reset_n,
  program_loader_ctrl_if.master io_bus
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_SYNC, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK, ST_RUN, ST_ERROR
  } state_t;
  localparam state_t ST_END = ST_CHECK;
  localparam state_t ST_LAST = ST_CHECK;
`else
  typedef enum logic [2:0] {
    ST_SYNC, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_DRAIN, ST_RUN, ST_ERROR
  } state_t;
  localparam state_t ST_END = ST_RUN;
  localparam state_t ST_LAST = ST_DRAIN;
`endif

  localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_len, w_len_nxt, w_len_full;
  logic [1:0]  r_byte_idx, w_byte_idx_nxt;
  logic [15:0] r_word_idx, w_word_idx_nxt;
  logic [23:0] r_asm, w_asm_nxt;
  logic        r_mem_sel, w_mem_sel_nxt;
  logic [31:0] r_mem_addr, w_mem_addr_nxt;
  logic        r_mem_we, w_mem_we_nxt;
  logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
  logic        r_cpu_reset_n, w_cpu_reset_n_nxt;
  logic        r_load_done, w_load_done_nxt;
  logic        r_load_error, w_load_error_nxt;
  logic [15:0] r_words_loaded, w_words_nxt;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_csum, w_csum_nxt;
`endif

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= ST_SYNC;
      r_len          <= 16'd0;
      r_byte_idx     <= 2'd0;
      r_word_idx     <= 16'd0;
      r_asm          <= 24'd0;
      r_mem_sel      <= 1'b1;
      r_mem_addr     <= 32'd0;
      r_mem_we       <= 1'b0;
      r_mem_wdata    <= 32'd0;
      r_cpu_reset_n  <= 1'b0;
      r_load_done    <= 1'b0;
      r_load_error   <= 1'b0;
      r_words_loaded <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
      r_csum         <= 8'd0;
`endif
    end else begin
      r_state        <= w_state_nxt;
      r_len          <= w_len_nxt;
      r_byte_idx     <= w_byte_idx_nxt;
      r_word_idx     <= w_word_idx_nxt;
      r_asm          <= w_asm_nxt;
      r_mem_sel      <= w_mem_sel_nxt;
      r_mem_addr     <= w_mem_addr_nxt;
      r_mem_we       <= w_mem_we_nxt;
      r_mem_wdata    <= w_mem_wdata_nxt;
      r_cpu_reset_n  <= w_cpu_reset_n_nxt;
      r_load_done    <= w_load_done_nxt;
      r_load_error   <= w_load_error_nxt;
      r_words_loaded <= w_words_nxt;
`ifdef LOADER_CHECKSUM_EN
      r_csum         <= w_csum_nxt;
`endif
    end
  end

  // Next-state and next-output logic; outputs follow the next state so they stay registered
  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_byte_idx_nxt  = r_byte_idx;
    w_word_idx_nxt  = r_word_idx;
    w_asm_nxt       = r_asm;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_words_nxt     = r_words_loaded;
    w_len_full      = {io_bus.rx_data, r_len[7:0]};
`ifdef LOADER_CHECKSUM_EN
    w_csum_nxt      = r_csum;
`endif
    case (r_state)
      ST_SYNC: begin
        if (io_bus.rx_valid && (io_bus.rx_data == SYNC_BYTE)) begin
          w_state_nxt = ST_LEN_LO;
        end else begin
          w_state_nxt = ST_SYNC;
        end
      end
      ST_LEN_LO: begin
        if (io_bus.rx_valid) begin
          w_len_nxt   = {8'd0, io_bus.rx_data};
          w_state_nxt = ST_LEN_HI;
        end else begin
          w_state_nxt = ST_LEN_LO;
        end
      end
      ST_LEN_HI: begin
        if (io_bus.rx_valid) begin
          w_len_nxt = w_len_full;
          if ({16'd0, w_len_full} > MEM_WORDS_U) begin
            w_state_nxt = ST_ERROR;
          end else if (w_len_full != 16'd0) begin
            w_state_nxt = ST_DATA;
          end else begin
            w_state_nxt = ST_END;
          end
        end else begin
          w_state_nxt = ST_LEN_HI;
        end
      end
      ST_DATA: begin
        if (io_bus.rx_valid) begin
          // Little-endian assembly: earlier bytes shift toward the low end
          w_asm_nxt      = {io_bus.rx_data, r_asm[23:8]};
          w_byte_idx_nxt = r_byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          w_csum_nxt     = r_csum ^ io_bus.rx_data;
`endif
          if (r_byte_idx == 2'd3) begin
            w_mem_we_nxt    = 1'b1;
            w_mem_wdata_nxt = {io_bus.rx_data, r_asm};
            w_mem_addr_nxt  = {14'd0, r_word_idx, 2'b00};
            w_words_nxt     = r_words_loaded + 16'd1;
            w_word_idx_nxt  = r_word_idx + 16'd1;
            if ((r_word_idx + 16'd1) == r_len) begin
              w_state_nxt = ST_LAST;
            end else begin
              w_state_nxt = ST_DATA;
            end
          end else begin
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (io_bus.rx_valid) begin
          if (io_bus.rx_data == r_csum) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_ERROR;
          end
        end else begin
          w_state_nxt = ST_CHECK;
        end
      end
`else
      ST_DRAIN: begin
        w_state_nxt = ST_RUN;
      end
`endif
      ST_RUN:   w_state_nxt = ST_RUN;
      ST_ERROR: w_state_nxt = ST_ERROR;
      default:  w_state_nxt = ST_SYNC;
    endcase
    w_mem_sel_nxt     = (w_state_nxt != ST_RUN);
    w_cpu_reset_n_nxt = (w_state_nxt == ST_RUN);
    w_load_done_nxt   = (w_state_nxt == ST_RUN);
    w_load_error_nxt  = (w_state_nxt == ST_ERROR);
  end

  assign io_bus.mem_sel      = r_mem_sel;
  assign io_bus.mem_addr     = r_mem_addr;
  assign io_bus.mem_we       = r_mem_we;
  assign io_bus.mem_wdata    = r_mem_wdata;
  assign io_bus.cpu_reset_n  = r_cpu_reset_n;
  assign io_bus.load_done    = r_load_done;
  assign io_bus.load_error   = r_load_error;
  assign io_bus.words_loaded = r_words_loaded;

endmodule

// File: tb/tb_program_loader_ctrl.sv
// Directed bench for program_loader_ctrl (MEM_WORDS=4); checksum cases build under LOADER_CHECKSUM_EN.
module tb_program_loader_ctrl;
  logic clk;
  logic reset_n;
  program_loader_ctrl_if bus ();

  program_loader_ctrl #(.MEM_WORDS(4), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_fail;
  int          wr_n;
  logic [31:0] wr_addr [0:15];
  logic [31:0] wr_data [0:15];
  logic        overlap;
  logic [4:0]  stat;

  assign stat = {bus.mem_sel, bus.mem_we, bus.cpu_reset_n, bus.load_done, bus.load_error};

  // Write log, sampled just after each active edge
  always @(posedge clk) begin
    #1;
    if (bus.mem_we === 1'b1) begin
      if (wr_n < 16) begin
        wr_addr[wr_n] = bus.mem_addr;
        wr_data[wr_n] = bus.mem_wdata;
      end
      wr_n = wr_n + 1;
      if (bus.mem_sel !== 1'b1) overlap = 1'b1;
    end
  end

  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    bus.rx_valid = v;
    bus.rx_data  = d;
  endtask

  task automatic send(input logic [7:0] q[$]);
    foreach (q[i]) drive(1'b1, q[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    wr_n = 0;
    overlap = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (stat !== 5'b10000) begin
      n_fail++; $display("FAIL reset_status: got %b want %b", stat, 5'b10000);
    end
    n_checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.words_loaded} !== 80'd0) begin
      n_fail++; $display("FAIL reset_regs: got %h %h %h want 0", bus.mem_addr, bus.mem_wdata, bus.words_loaded);
    end
  endtask

  task automatic test_two_words();
    do_reset();
    send('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00});
`ifdef LOADER_CHECKSUM_EN
    drive(1'b1, 8'h90);
`else
    drive(1'b0, 8'h00);
`endif
    n_checks++;
    if (stat !== 5'b11000) begin
      n_fail++; $display("FAIL two_last_write_status: got %b want %b", stat, 5'b11000);
    end
    n_checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.words_loaded} !== {32'h4, 32'h00100093, 16'd2}) begin
      n_fail++; $display("FAIL two_last_write: got %h %h %0d want 4 00100093 2", bus.mem_addr, bus.mem_wdata, bus.words_loaded);
    end
    drive(1'b0, 8'h00);
    n_checks++;
    if (stat !== 5'b00110) begin
      n_fail++; $display("FAIL two_run_status: got %b want %b", stat, 5'b00110);
    end
    n_checks++;
    if (wr_n !== 2 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h00000013 || wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h00100093) begin
      n_fail++; $display("FAIL two_write_log: got n=%0d %h:%h %h:%h want 2 0:00000013 4:00100093", wr_n, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
    n_checks++;
    if (overlap !== 1'b0) begin
      n_fail++; $display("FAIL two_we_overlap: got %b want 0", overlap);
    end
  endtask

  task automatic test_garbage();
    do_reset();
    send('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
`ifdef LOADER_CHECKSUM_EN
    drive(1'b1, 8'h22);
`else
    drive(1'b0, 8'h00);
`endif
    drive(1'b0, 8'h00);
    n_checks++;
    if (stat !== 5'b00110) begin
      n_fail++; $display("FAIL garbage_run_status: got %b want %b", stat, 5'b00110);
    end
    n_checks++;
    if (wr_n !== 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hDEADBEEF || bus.words_loaded !== 16'd1) begin
      n_fail++; $display("FAIL garbage_write: got n=%0d %h:%h wl=%0d want 1 0:deadbeef 1", wr_n, wr_addr[0], wr_data[0], bus.words_loaded);
    end
  endtask

  task automatic test_len_error();
    do_reset();
    send('{8'hA5, 8'h05, 8'h00});
    drive(1'b0, 8'h00);
    n_checks++;
    if (stat !== 5'b10001) begin
      n_fail++; $display("FAIL len_err_status: got %b want %b", stat, 5'b10001);
    end
    send('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44});
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    n_checks++;
    if (stat !== 5'b10001 || wr_n !== 0 || bus.words_loaded !== 16'd0) begin
      n_fail++; $display("FAIL len_err_sticky: got %b n=%0d wl=%0d want 10001 0 0", stat, wr_n, bus.words_loaded);
    end
  endtask

  task automatic test_max_len();
    do_reset();
    send('{8'hA5, 8'h04, 8'h00});
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(i));
`ifdef LOADER_CHECKSUM_EN
    drive(1'b1, 8'h00);
`endif
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    n_checks++;
    if (stat !== 5'b00110 || bus.words_loaded !== 16'd4) begin
      n_fail++; $display("FAIL max_len_run: got %b wl=%0d want 00110 4", stat, bus.words_loaded);
    end
    n_checks++;
    if (wr_n !== 4 || wr_addr[3] !== 32'hC || wr_data[3] !== 32'h0F0E0D0C || wr_data[0] !== 32'h03020100) begin
      n_fail++; $display("FAIL max_len_writes: got n=%0d %h:%h %h want 4 c:0f0e0d0c 03020100", wr_n, wr_addr[3], wr_data[3], wr_data[0]);
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    send('{8'hA5, 8'h00, 8'h00});
`ifdef LOADER_CHECKSUM_EN
    drive(1'b1, 8'h00);
`endif
    drive(1'b0, 8'h00);
    n_checks++;
    if (stat !== 5'b00110 || bus.words_loaded !== 16'd0 || wr_n !== 0) begin
      n_fail++; $display("FAIL zero_len: got %b wl=%0d n=%0d want 00110 0 0", stat, bus.words_loaded, wr_n);
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    send('{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33});
    do_reset();
    n_checks++;
    if (stat !== 5'b10000 || {bus.mem_addr, bus.mem_wdata, bus.words_loaded} !== 80'd0) begin
      n_fail++; $display("FAIL midload_reset: got %b %h %h %h want 10000 0 0 0", stat, bus.mem_addr, bus.mem_wdata, bus.words_loaded);
    end
    send('{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12});
`ifdef LOADER_CHECKSUM_EN
    drive(1'b1, 8'h08);
`endif
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    n_checks++;
    if (stat !== 5'b00110 || wr_n !== 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h12345678 || bus.words_loaded !== 16'd1) begin
      n_fail++; $display("FAIL midload_reload: got %b n=%0d %h:%h wl=%0d want 00110 1 0:12345678 1", stat, wr_n, wr_addr[0], wr_data[0], bus.words_loaded);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    send('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44});
    n_checks++;
    if (stat !== 5'b11000) begin
      n_fail++; $display("FAIL csum_check_state: got %b want %b", stat, 5'b11000);
    end
    drive(1'b0, 8'h00);
    n_checks++;
    if (stat !== 5'b00110) begin
      n_fail++; $display("FAIL csum_good: got %b want %b", stat, 5'b00110);
    end
    do_reset();
    send('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45});
    drive(1'b0, 8'h00);
    n_checks++;
    if (stat !== 5'b10001) begin
      n_fail++; $display("FAIL csum_bad: got %b want %b", stat, 5'b10001);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail = 0;
    wr_n = 0;
    overlap = 1'b0;
    reset_n = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    test_reset();
    test_two_words();
    test_garbage();
    test_len_error();
    test_max_len();
    test_zero_len();
    test_reset_mid_load();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
